// File: rtl/dump_pkg.sv
// Shared types and configuration checks for the halt dump engine.
package dump_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EMIT,
        S_REGS,
        S_DONE
    } dump_state_e;

    localparam logic KIND_MEM = 1'b0;
    localparam logic KIND_REG = 1'b1;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    // Register lines must tile the line exactly and the register file must fill whole lines.
    function automatic bit dump_cfg_ok(input int line_bytes, input int reg_w, input int reg_count);
        if (!is_pow2(line_bytes) || line_bytes < 4) return 1'b0;
        if (reg_w <= 0 || (reg_w % 8) != 0) return 1'b0;
        if (((line_bytes * 8) % reg_w) != 0) return 1'b0;
        return (reg_count % ((line_bytes * 8) / reg_w)) == 0;
    endfunction

endpackage

// File: rtl/halt_dump_engine_if.sv
// Memory/register read ports and the line output stream of the dump engine.
interface halt_dump_engine_if #(
    parameter int ADDR_W     = 16,
    parameter int LINE_BYTES = 16,
    parameter int REG_COUNT  = 32,
    parameter int REG_W      = 32
);
    logic                         mem_en;
    logic [ADDR_W-1:0]            mem_addr;
    logic [7:0]                   mem_rdata;
    logic [$clog2(REG_COUNT)-1:0] reg_addr;
    logic [REG_W-1:0]             reg_rdata;
    logic                         out_valid;
    logic                         out_ready;
    logic [LINE_BYTES*8-1:0]      out_data;
    logic [ADDR_W-1:0]            out_addr;
    logic                         out_kind;
    logic                         out_last;

    modport master (
        output mem_en, mem_addr, reg_addr,
        input  mem_rdata, reg_rdata,
        output out_valid, out_data, out_addr, out_kind, out_last,
        input  out_ready
    );

    modport slave (
        input  mem_en, mem_addr, reg_addr,
        output mem_rdata, reg_rdata,
        input  out_valid, out_data, out_addr, out_kind, out_last,
        output out_ready
    );
endinterface

// File: rtl/halt_dump_engine_line_assembler.sv
// Line capture register: memory bytes or register words written by index.
module line_assembler #(
    parameter int  LINE_BYTES = 16,
    parameter int  REG_W      = 32,
    localparam int BIW        = $clog2(LINE_BYTES),
    localparam int WORDS      = LINE_BYTES * 8 / REG_W,
    localparam int WIW        = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    byte_we,
    input  logic [BIW-1:0]          byte_idx,
    input  logic [7:0]              byte_data,
    input  logic                    word_we,
    input  logic [WIW-1:0]          word_idx,
    input  logic [REG_W-1:0]        word_data,
    output logic [LINE_BYTES*8-1:0] line
);
    localparam int BPW = REG_W / 8;

    logic [LINE_BYTES-1:0][7:0] q;

    always_ff @(posedge clk) begin
        for (int b = 0; b < LINE_BYTES; b++) begin
            if (rst || clr)
                q[b] <= '0;
            else if (byte_we && byte_idx == BIW'(b))
                q[b] <= byte_data;
            else if (word_we && word_idx == WIW'(b / BPW))
                q[b] <= word_data[8*(b % BPW) +: 8];
        end
    end

    assign line = q;
endmodule

// File: rtl/halt_dump_engine.sv
// Streams memory regions then the register file as packed lines once the CPU halts.
module halt_dump_engine
    import dump_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int LINE_BYTES  = 16,
    parameter int NUM_REGIONS = 4,
    parameter int REG_COUNT   = 32,
    parameter int REG_W       = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          halt,
    input  logic [NUM_REGIONS*ADDR_W-1:0] region_base,
    input  logic [NUM_REGIONS*ADDR_W-1:0] region_lines,
    halt_dump_engine_if.master            dif,
    output logic                          busy,
    output logic                          done
);
    localparam int RPL  = LINE_BYTES * 8 / REG_W;
    localparam int NGRP = REG_COUNT / RPL;
    localparam int KW   = $clog2(LINE_BYTES);
    localparam int RW   = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int JW   = (RPL > 1) ? $clog2(RPL) : 1;
    localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int RAW  = $clog2(REG_COUNT);

    if (!dump_cfg_ok(LINE_BYTES, REG_W, REG_COUNT)) begin : g_bad_cfg
        $error("halt_dump_engine: illegal LINE_BYTES/REG_W/REG_COUNT combination");
    end

    dump_state_e state, state_n;

    logic [NUM_REGIONS-1:0][ADDR_W-1:0] rbase, rlen;
    logic [RW-1:0]      r;
    logic [ADDR_W-1:0]  line;
    logic [KW-1:0]      k;
    logic [JW-1:0]      j;
    logic [GW-1:0]      grp;
    logic               cap_vld;
    logic [KW-1:0]      cap_idx;
    logic [ADDR_W-1:0]  out_addr_q;
    logic               out_kind_q;
    logic               out_last_q;

    logic                   start;
    logic [NUM_REGIONS-1:0] mask_in, mask_lat;
    logic [RW:0]            nxt_in, nxt_lat;
    logic [ADDR_W-1:0]      line_addr;
    logic                   last_line;

    // Lowest non-empty region at or above 'from'; MSB flags that one exists.
    function automatic logic [RW:0] next_region(input logic [NUM_REGIONS-1:0] m, input int from);
        logic [RW:0] res;
        res = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--)
            if (i >= from && m[i]) res = {1'b1, RW'(i)};
        return res;
    endfunction

    always_comb begin
        mask_in  = '0;
        mask_lat = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            mask_in[i]  = region_lines[i*ADDR_W +: ADDR_W] != '0;
            mask_lat[i] = rlen[i] != '0;
        end
        nxt_in  = next_region(mask_in, 0);
        nxt_lat = next_region(mask_lat, int'(r) + 1);
    end

    assign start     = (state == S_IDLE) && halt;
    assign line_addr = rbase[r] + (line << KW);
    assign last_line = line == rlen[r] - ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (halt) state_n = nxt_in[RW] ? S_FETCH : S_REGS;
            S_FETCH: if (k == KW'(LINE_BYTES - 1)) state_n = S_WAIT;
            S_WAIT:  state_n = S_EMIT;
            S_REGS:  if (j == JW'(RPL - 1)) state_n = S_EMIT;
            S_EMIT: begin
                if (dif.out_ready) begin
                    if (out_kind_q == KIND_REG) state_n = out_last_q ? S_DONE : S_REGS;
                    else if (!last_line || nxt_lat[RW]) state_n = S_FETCH;
                    else state_n = S_REGS;
                end
            end
            S_DONE:  state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rbase      <= '0;
            rlen       <= '0;
            r          <= '0;
            line       <= '0;
            k          <= '0;
            j          <= '0;
            grp        <= '0;
            cap_vld    <= 1'b0;
            cap_idx    <= '0;
            out_addr_q <= '0;
            out_kind_q <= KIND_MEM;
            out_last_q <= 1'b0;
        end else begin
            // Memory data arrives a cycle after the strobe, so the capture index trails k.
            cap_vld <= (state == S_FETCH);
            cap_idx <= k;
            case (state)
                S_IDLE: if (halt) begin
                    rbase <= region_base;
                    rlen  <= region_lines;
                    r     <= nxt_in[RW-1:0];
                    line  <= '0;
                    k     <= '0;
                    j     <= '0;
                    grp   <= '0;
                end
                S_FETCH: k <= k + KW'(1);
                S_WAIT: begin
                    out_addr_q <= line_addr;
                    out_kind_q <= KIND_MEM;
                    out_last_q <= 1'b0;
                end
                S_REGS: begin
                    j <= (j == JW'(RPL - 1)) ? '0 : j + JW'(1);
                    if (j == JW'(RPL - 1)) begin
                        out_addr_q <= ADDR_W'(int'(grp) * RPL);
                        out_kind_q <= KIND_REG;
                        out_last_q <= grp == GW'(NGRP - 1);
                    end
                end
                S_EMIT: if (dif.out_ready) begin
                    if (out_kind_q == KIND_REG) begin
                        grp <= grp + GW'(1);
                    end else if (last_line) begin
                        line <= '0;
                        if (nxt_lat[RW]) r <= nxt_lat[RW-1:0];
                    end else begin
                        line <= line + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    line_assembler #(.LINE_BYTES(LINE_BYTES), .REG_W(REG_W)) u_asm (
        .clk       (clk),
        .rst       (rst),
        .clr       (start),
        .byte_we   (cap_vld),
        .byte_idx  (cap_idx),
        .byte_data (dif.mem_rdata),
        .word_we   (state == S_REGS),
        .word_idx  (j),
        .word_data (dif.reg_rdata),
        .line      (dif.out_data)
    );

    assign dif.mem_en    = (state == S_FETCH);
    assign dif.mem_addr  = line_addr + ADDR_W'(k);
    assign dif.reg_addr  = RAW'(int'(grp) * RPL + int'(j));
    assign dif.out_valid = (state == S_EMIT);
    assign dif.out_addr  = out_addr_q;
    assign dif.out_kind  = out_kind_q;
    assign dif.out_last  = out_last_q;
    assign busy          = (state == S_FETCH) || (state == S_WAIT) ||
                           (state == S_EMIT)  || (state == S_REGS);
    assign done          = (state == S_DONE);
endmodule

// File: tb/tb_halt_dump_engine.sv
// Scoreboard bench for halt_dump_engine: expected lines queued per dump, popped on handshake.
module tb_halt_dump_engine;
    localparam int ADDR_W = 16;
    localparam int LB     = 16;
    localparam int NR     = 4;
    localparam int RC     = 32;
    localparam int RGW    = 32;

    typedef struct {
        logic [127:0] data;
        logic [15:0]  addr;
        logic         kind;
        logic         last;
    } line_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic halt = 1'b0;
    logic [NR*ADDR_W-1:0] region_base, region_lines;
    logic busy, done;

    logic [15:0] cfg_base [NR];
    logic [15:0] cfg_lines[NR];
    logic [7:0]  mem[65536];
    logic [31:0] rf[RC];
    line_t       exp_q[$];
    int          n_chk = 0;
    int          n_err = 0;

    halt_dump_engine_if #(.ADDR_W(ADDR_W), .LINE_BYTES(LB), .REG_COUNT(RC), .REG_W(RGW)) dif();

    halt_dump_engine #(
        .ADDR_W(ADDR_W), .LINE_BYTES(LB), .NUM_REGIONS(NR), .REG_COUNT(RC), .REG_W(RGW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .halt         (halt),
        .region_base  (region_base),
        .region_lines (region_lines),
        .dif          (dif),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk)
        if (dif.mem_en) dif.mem_rdata <= mem[dif.mem_addr];

    assign dif.reg_rdata = rf[dif.reg_addr];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        halt = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive the region ports from cfg_* and queue the full expected dump.
    task automatic load_cfg();
        line_t e;
        exp_q.delete();
        for (int r = 0; r < NR; r++) begin
            region_base[r*ADDR_W +: ADDR_W]  = cfg_base[r];
            region_lines[r*ADDR_W +: ADDR_W] = cfg_lines[r];
            for (int l = 0; l < int'(cfg_lines[r]); l++) begin
                e.addr = cfg_base[r] + 16'(l * LB);
                for (int k = 0; k < LB; k++) e.data[8*k +: 8] = mem[16'(e.addr + 16'(k))];
                e.kind = 1'b0;
                e.last = 1'b0;
                exp_q.push_back(e);
            end
        end
        for (int g = 0; g < RC / 4; g++) begin
            for (int i = 0; i < 4; i++) e.data[32*i +: 32] = rf[4*g + i];
            e.addr = 16'(4 * g);
            e.kind = 1'b1;
            e.last = (g == RC / 4 - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic consume(input int stall, input int halt_len, output int first_vld, output int n_en);
        int           st = 0;
        int           cyc = 0;
        logic [127:0] held = '0;
        line_t        e;
        first_vld = -1;
        n_en      = 0;
        while (cyc < 4000 && done !== 1'b1) begin
            @(negedge clk);
            cyc++;
            if (cyc == halt_len) halt = 1'b0;
            if (cyc == 5) begin
                region_base  = ~region_base;
                region_lines = {NR{16'h0003}};
            end
            if (dif.mem_en === 1'b1) n_en++;
            if (dif.out_valid === 1'b1 && first_vld < 0) first_vld = cyc;
            if (dif.out_valid === 1'b1 && st < stall) begin
                if (st > 0) chk("stall_data", dif.out_data, held);
                chk("stall_no_read", 128'(dif.mem_en), 128'(0));
                held = dif.out_data;
                st++;
                dif.out_ready = 1'b0;
            end else begin
                dif.out_ready = 1'b1;
                if (dif.out_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_line", 128'(exp_q.size()), 128'(1));
                    end else begin
                        e = exp_q.pop_front();
                        chk("line_data", dif.out_data, e.data);
                        chk("line_addr", 128'(dif.out_addr), 128'(e.addr));
                        chk("line_kind", 128'(dif.out_kind), 128'(e.kind));
                        chk("line_last", 128'(dif.out_last), 128'(e.last));
                    end
                end
            end
        end
        dif.out_ready = 1'b1;
        chk("dump_done", 128'(done), 128'(1));
        chk("lines_left", 128'(exp_q.size()), 128'(0));
        chk("busy_after", 128'(busy), 128'(0));
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_mem_en"},    128'(dif.mem_en),    128'(0));
        chk({pfx, "_mem_addr"},  128'(dif.mem_addr),  128'(0));
        chk({pfx, "_reg_addr"},  128'(dif.reg_addr),  128'(0));
        chk({pfx, "_out_valid"}, 128'(dif.out_valid), 128'(0));
        chk({pfx, "_out_data"},  dif.out_data,        128'(0));
        chk({pfx, "_out_addr"},  128'(dif.out_addr),  128'(0));
        chk({pfx, "_out_kind"},  128'(dif.out_kind),  128'(0));
        chk({pfx, "_out_last"},  128'(dif.out_last),  128'(0));
        chk({pfx, "_busy"},      128'(busy),          128'(0));
        chk({pfx, "_done"},      128'(done),          128'(0));
    endtask

    initial begin
        int fv, ne, quiet;
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'(i >> 8);
        for (int i = 0; i < RC; i++) rf[i] = 32'(i);
        rf[0] = 32'hDEADBEEF;
        dif.out_ready = 1'b1;
        region_base   = '0;
        region_lines  = '0;

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Single line at 0x0000, then the register file.
        cfg_base  = '{16'h0000, 16'h1111, 16'h2222, 16'h3333};
        cfg_lines = '{16'd1, 16'd0, 16'd0, 16'd0};
        load_cfg();
        halt = 1'b1;
        consume(0, 0, fv, ne);
        chk("halt_to_valid", 128'(fv), 128'(LB + 2));
        chk("mem_reads_1", 128'(ne), 128'(LB));

        // Done is sticky: a fresh halt edge must not start another dump.
        halt  = 1'b0;
        quiet = 0;
        repeat (3) @(negedge clk);
        halt = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (dif.out_valid !== 1'b0 || dif.mem_en !== 1'b0) quiet++;
        end
        chk("post_done_quiet", 128'(quiet), 128'(0));
        chk("post_done_done", 128'(done), 128'(1));

        // Backpressure on the first line, halt dropped mid-dump.
        do_reset();
        load_cfg();
        halt = 1'b1;
        consume(5, 3, fv, ne);
        chk("mem_reads_stall", 128'(ne), 128'(LB));

        // Sparse region table.
        do_reset();
        cfg_base  = '{16'h8000, 16'h1234, 16'h9000, 16'h4321};
        cfg_lines = '{16'd2, 16'd0, 16'd1, 16'd0};
        load_cfg();
        halt = 1'b1;
        consume(0, 0, fv, ne);
        chk("mem_reads_sparse", 128'(ne), 128'(3 * LB));

        // Address wrap at the top of memory.
        do_reset();
        cfg_base  = '{16'hFFF0, 16'h0000, 16'h0000, 16'h0000};
        cfg_lines = '{16'd2, 16'd0, 16'd0, 16'd0};
        load_cfg();
        halt = 1'b1;
        consume(0, 0, fv, ne);
        chk("mem_reads_wrap", 128'(ne), 128'(2 * LB));

        // Reset during FETCH with halt held: clean restart from region 0.
        do_reset();
        cfg_base  = '{16'h0100, 16'h0000, 16'h0000, 16'h0000};
        cfg_lines = '{16'd1, 16'd0, 16'd0, 16'd0};
        load_cfg();
        halt = 1'b1;
        repeat (5) @(negedge clk);
        chk("midfetch_mem_en", 128'(dif.mem_en), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midrst");
        rst = 1'b0;
        load_cfg();
        consume(0, 0, fv, ne);
        chk("restart_to_valid", 128'(fv), 128'(LB + 2));
        chk("mem_reads_restart", 128'(ne), 128'(LB));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
